// File: rtl/relay_bnt_ctrl.sv
// rtl/relay_bnt_ctrl.sv - multi-channel debounced push-button to relay controller
// Each channel: 2-flop sync, debounce, momentary/toggle target, relay with minimum dwell.
module relay_bnt_ctrl #(
  parameter int           N        = 4,
  parameter int           DEB_CYC  = 500000,
  parameter int           HOLD_CYC = 50000,
  parameter logic [N-1:0] MODE     = {N{1'b1}}
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         EN,
  input  logic [N-1:0] BNT,
  output logic [N-1:0] RELAY,
  output logic [N-1:0] PRESS
);

  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int HW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD_CYC);

  logic [N-1:0]  s1;
  logic [N-1:0]  s2;
  logic [N-1:0]  deb;
  logic [N-1:0]  tgl;
  logic [DW-1:0] dcnt [N];
  logic [HW-1:0] hcnt [N];

  logic [N-1:0]  press_ev;
  logic [N-1:0]  target;

  // A press is the edge on which the debounced level is accepted going 1->0.
  always_comb begin
    press_ev = '0;
    target   = '0;
    for (int i = 0; i < N; i++) begin
      press_ev[i] = deb[i] & ~s2[i] & (dcnt[i] == DEB_LAST);
      target[i]   = MODE[i] ? tgl[i] : ~deb[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1    <= '1;
      s2    <= '1;
      deb   <= '1;
      tgl   <= '0;
      RELAY <= '0;
      PRESS <= '0;
      for (int i = 0; i < N; i++) begin
        dcnt[i] <= '0;
        hcnt[i] <= '0;
      end
    end else begin
      s1    <= BNT;
      s2    <= s1;
      PRESS <= press_ev;
      for (int i = 0; i < N; i++) begin
        if (s2[i] != deb[i]) begin
          if (dcnt[i] == DEB_LAST) begin
            deb[i]  <= s2[i];
            dcnt[i] <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + DW'(1);
          end
        end else begin
          dcnt[i] <= '0;
        end

        // Disable overrides the dwell so relays drop immediately.
        if (!EN) begin
          RELAY[i] <= 1'b0;
          tgl[i]   <= 1'b0;
          hcnt[i]  <= '0;
        end else begin
          if (press_ev[i] && MODE[i]) begin
            tgl[i] <= ~tgl[i];
          end
          if ((target[i] != RELAY[i]) && (hcnt[i] == '0)) begin
            RELAY[i] <= target[i];
            hcnt[i]  <= HOLD_LD;
          end else if (hcnt[i] != '0) begin
            hcnt[i] <= hcnt[i] - HW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_relay_bnt_ctrl.sv
// tb/tb_relay_bnt_ctrl.sv - directed scoreboard bench for relay_bnt_ctrl
module tb_relay_bnt_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       EN = 1'b1;
  logic [1:0] BNT = 2'b11;
  logic [1:0] RELAY;
  logic [1:0] PRESS;

  int checks = 0;
  int errors = 0;
  logic [3:0] sb [$];

  relay_bnt_ctrl #(
    .N(2), .DEB_CYC(4), .HOLD_CYC(8), .MODE(2'b10)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .BNT(BNT), .RELAY(RELAY), .PRESS(PRESS)
  );

  always #5 CLK = ~CLK;

  // Drive n cycles with fixed inputs; each cycle's expected {RELAY,PRESS} is queued then checked 1 after the edge.
  task automatic run(input int n, input logic [1:0] b, input logic e, input logic r,
                     input logic [1:0] er, input logic [1:0] ep, input string tag);
    logic [3:0] exp_v;
    for (int k = 0; k < n; k++) begin
      BNT   = b;
      EN    = e;
      RST_N = r;
      sb.push_back({er, ep});
      @(posedge CLK);
      #1;
      exp_v = sb.pop_front();
      checks++;
      assert ({RELAY, PRESS} === exp_v) else begin
        errors++;
        $error("FAIL %s step %0d: relay/press observed %b/%b expected %b/%b",
               tag, k, RELAY, PRESS, exp_v[3:2], exp_v[1:0]);
      end
    end
  endtask

  initial begin
    run(2, 2'b11, 1, 0, 2'b00, 2'b00, "reset");
    run(5, 2'b11, 1, 1, 2'b00, 2'b00, "idle");

    // ch0 momentary press and release
    run(5,  2'b10, 1, 1, 2'b00, 2'b00, "m_debounce");
    run(1,  2'b10, 1, 1, 2'b00, 2'b01, "m_press");
    run(1,  2'b10, 1, 1, 2'b01, 2'b00, "m_on");
    run(5,  2'b10, 1, 1, 2'b01, 2'b00, "m_hold");
    run(6,  2'b11, 1, 1, 2'b01, 2'b00, "m_release_wait");
    run(1,  2'b11, 1, 1, 2'b00, 2'b00, "m_off");
    run(12, 2'b11, 1, 1, 2'b00, 2'b00, "m_drain");

    // bounce on ch0 never accepted
    for (int j = 0; j < 5; j++) begin
      run(2, 2'b10, 1, 1, 2'b00, 2'b00, "bounce_lo");
      run(2, 2'b11, 1, 1, 2'b00, 2'b00, "bounce_hi");
    end
    run(6, 2'b11, 1, 1, 2'b00, 2'b00, "bounce_settle");

    // ch1 toggle: three presses, second relay change withheld by dwell
    run(4,  2'b01, 1, 1, 2'b00, 2'b00, "t1_low");
    run(1,  2'b11, 1, 1, 2'b00, 2'b00, "t1_wait");
    run(1,  2'b11, 1, 1, 2'b00, 2'b10, "t1_press");
    run(2,  2'b11, 1, 1, 2'b10, 2'b00, "t1_on");
    run(4,  2'b01, 1, 1, 2'b10, 2'b00, "t2_low");
    run(1,  2'b11, 1, 1, 2'b10, 2'b00, "t2_wait");
    run(1,  2'b11, 1, 1, 2'b10, 2'b10, "t2_press");
    run(1,  2'b11, 1, 1, 2'b10, 2'b00, "t2_withheld");
    run(1,  2'b11, 1, 1, 2'b00, 2'b00, "t2_off");
    run(4,  2'b01, 1, 1, 2'b00, 2'b00, "t3_low");
    run(1,  2'b11, 1, 1, 2'b00, 2'b00, "t3_wait");
    run(1,  2'b11, 1, 1, 2'b00, 2'b10, "t3_press");
    run(2,  2'b11, 1, 1, 2'b00, 2'b00, "t3_withheld");
    run(1,  2'b11, 1, 1, 2'b10, 2'b00, "t3_on");
    run(10, 2'b11, 1, 1, 2'b10, 2'b00, "t_final");

    // EN drop with both relays on and ch0 dwell active
    run(5, 2'b10, 1, 1, 2'b10, 2'b00, "en_deb");
    run(1, 2'b10, 1, 1, 2'b10, 2'b01, "en_press");
    run(1, 2'b10, 1, 1, 2'b11, 2'b00, "en_both_on");
    run(2, 2'b10, 0, 1, 2'b00, 2'b00, "en_off");
    run(1, 2'b10, 1, 1, 2'b01, 2'b00, "en_restore");
    run(4, 2'b10, 1, 1, 2'b01, 2'b00, "en_hold");

    // reset mid-dwell with both buttons held through it
    run(5, 2'b00, 1, 1, 2'b01, 2'b00, "rst_deb");
    run(1, 2'b00, 1, 1, 2'b01, 2'b10, "rst_press");
    run(1, 2'b00, 1, 1, 2'b11, 2'b00, "rst_dwell");
    run(1, 2'b00, 1, 0, 2'b00, 2'b00, "rst_assert");
    run(5, 2'b00, 1, 1, 2'b00, 2'b00, "rst_redeb");
    run(1, 2'b00, 1, 1, 2'b00, 2'b11, "rst_repress");
    run(1, 2'b00, 1, 1, 2'b11, 2'b00, "rst_relay_on");
    run(3, 2'b00, 1, 1, 2'b11, 2'b00, "rst_hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
